// File: rtl/viterbi_ber_checker_pkg.sv
// Shared types and constants for the encoder/decoder loopback BER checker.
// Holds the sync FSM state type, the default reference pattern and counter widths.
package viterbi_test_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } sync_state_t;

    localparam logic [31:0] DEFAULT_TEST_PATTERN = 32'h0200af31;

    localparam int DATA_W     = 8;
    localparam int BIT_CNT_W  = 32;
    localparam int ERR_CNT_W  = 32;
    localparam int SLIP_CNT_W = 16;
    localparam int LOSS_CNT_W = 16;

endpackage

// File: rtl/viterbi_ber_checker_if.sv
// Decoded-bit stream from viterbi_dec into the BER checker (AXI-stream style).
// Only bit 0 of s_tdata carries information; the checker never back-pressures.
interface viterbi_ber_checker_if;
    import viterbi_test_pkg::*;

    logic              s_tvalid;
    logic              s_tready;
    logic [DATA_W-1:0] s_tdata;

    modport master (output s_tvalid, output s_tdata, input  s_tready);
    modport slave  (input  s_tvalid, input  s_tdata, output s_tready);

endinterface

// File: rtl/viterbi_ber_checker_sat_counter.sv
// Saturating statistics counter: holds at all-ones instead of wrapping.
// Updates one cycle after inc; clr has priority over inc.
module sat_counter #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic [AMT_W-1:0] amount,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH:0]   sum;

    // One extra bit catches the carry out so the counter can pin at all-ones.
    assign sum = {1'b0, cnt} + (WIDTH+1)'(amount);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        end
    end

    assign count = cnt;

endmodule

// File: rtl/viterbi_ber_checker.sv
// Aligns the decoded bit stream to the cyclic test pattern by slipping, then counts bits/errors while locked.
// All outputs registered (one cycle after the beat); s_tready is 1 from the cycle after reset, never back-pressures.
module viterbi_ber_checker
    import viterbi_test_pkg::*;
#(
    parameter int                  PAT_LEN       = 32,
    parameter logic [PAT_LEN-1:0]  PATTERN       = DEFAULT_TEST_PATTERN,
    parameter int                  WIN_LEN       = 64,
    parameter int                  LOCK_THRESH   = 2,
    parameter int                  UNLOCK_THRESH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    viterbi_ber_checker_if.slave  s,
    output logic                  locked,
    output logic [BIT_CNT_W-1:0]  bit_count,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic [SLIP_CNT_W-1:0] slip_count,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    localparam int PW  = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam int WCW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int WEW = $clog2(WIN_LEN + 1);

    sync_state_t    state, stateNext;
    logic [PW-1:0]  phase, phaseNext, patIdx;
    logic [WCW-1:0] winCnt;
    logic [WEW-1:0] winErr, winTotal;
    logic           ready;
    logic           beat, expBit, mis, winClose;
    logic           slipBeat, countBeat, lossBeat;
    logic           unusedData;

    assign unusedData = ^s.s_tdata[DATA_W-1:1];

    assign beat     = s.s_tvalid & ready;
    assign patIdx   = PW'(PAT_LEN - 1) - phase;
    assign expBit   = PATTERN[patIdx];
    assign mis      = s.s_tdata[0] ^ expBit;
    assign winTotal = winErr + WEW'(mis);
    assign winClose = (winCnt == WCW'(WIN_LEN - 1));

    // A slip skips one pattern position, shifting our phase one bit against the stream.
    assign phaseNext = PW'((int'(phase) + (slipBeat ? 2 : 1)) % PAT_LEN);

    always_comb begin
        stateNext = state;
        slipBeat  = 1'b0;
        countBeat = 1'b0;
        lossBeat  = 1'b0;
        if (beat) begin
            case (state)
                HUNT: begin
                    if (winClose) begin
                        if (winTotal <= WEW'(LOCK_THRESH)) begin
                            stateNext = LOCKED;
                        end else begin
                            slipBeat = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    countBeat = 1'b1;
                    if (winClose && (winTotal > WEW'(UNLOCK_THRESH))) begin
                        stateNext = HUNT;
                        lossBeat  = 1'b1;
                    end
                end
                default: stateNext = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= HUNT;
            phase  <= '0;
            winCnt <= '0;
            winErr <= '0;
            ready  <= 1'b0;
        end else begin
            ready <= 1'b1;
            state <= stateNext;
            if (beat) begin
                phase <= phaseNext;
                if (winClose) begin
                    winCnt <= '0;
                    winErr <= '0;
                end else begin
                    winCnt <= winCnt + WCW'(1);
                    winErr <= winTotal;
                end
            end
        end
    end

    assign s.s_tready = ready;
    assign locked     = (state == LOCKED);

    sat_counter #(.WIDTH(BIT_CNT_W), .AMT_W(1)) uBitCnt (
        .clk(clk), .reset(reset), .clr(clear),
        .inc(countBeat), .amount(1'b1), .count(bit_count)
    );

    sat_counter #(.WIDTH(ERR_CNT_W), .AMT_W(1)) uErrCnt (
        .clk(clk), .reset(reset), .clr(clear),
        .inc(countBeat), .amount(mis), .count(err_count)
    );

    sat_counter #(.WIDTH(SLIP_CNT_W), .AMT_W(1)) uSlipCnt (
        .clk(clk), .reset(reset), .clr(clear),
        .inc(slipBeat), .amount(1'b1), .count(slip_count)
    );

    sat_counter #(.WIDTH(LOSS_CNT_W), .AMT_W(1)) uLossCnt (
        .clk(clk), .reset(reset), .clr(clear),
        .inc(lossBeat), .amount(1'b1), .count(loss_count)
    );

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Directed + randomized bench for viterbi_ber_checker against a behavioural pattern-alignment model.
module tb_viterbi_ber_checker;
    import viterbi_test_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        locked;
    logic [31:0] bit_count, err_count;
    logic [15:0] slip_count, loss_count;

    viterbi_ber_checker_if busIf ();

    viterbi_ber_checker dut (
        .clk(clk), .reset(reset), .clear(clear), .s(busIf),
        .locked(locked), .bit_count(bit_count), .err_count(err_count),
        .slip_count(slip_count), .loss_count(loss_count)
    );

    always #5 clk = ~clk;

    int nAssert = 0;
    int nFail   = 0;

    // Reference model: what the checker should conclude from the spec rules alone.
    logic [31:0] patVec = DEFAULT_TEST_PATTERN;
    int     mP, mWinCnt, mWinErr;
    bit     mLocked, mReady;
    longint mBit, mErr, mSlip, mLoss;
    int     txPh;
    int     nBeats;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint satAdd(input longint v, input longint a, input longint maxv);
        return (v + a > maxv) ? maxv : v + a;
    endfunction

    function automatic void modelReset();
        mP = 0; mWinCnt = 0; mWinErr = 0;
        mLocked = 0; mReady = 0;
        mBit = 0; mErr = 0; mSlip = 0; mLoss = 0;
    endfunction

    function automatic void modelBeat(input bit d);
        bit mis;
        bit slip;
        int total;
        mis   = d ^ patVec[31 - mP];
        total = mWinErr + int'(mis);
        slip  = 0;
        if (mLocked) begin
            mBit = satAdd(mBit, 1, 64'hFFFF_FFFF);
            mErr = satAdd(mErr, longint'(mis), 64'hFFFF_FFFF);
        end
        if (mWinCnt == 63) begin
            if (!mLocked) begin
                if (total <= 2) mLocked = 1;
                else begin
                    slip  = 1;
                    mSlip = satAdd(mSlip, 1, 64'hFFFF);
                end
            end else if (total > 8) begin
                mLocked = 0;
                mLoss   = satAdd(mLoss, 1, 64'hFFFF);
            end
            mWinCnt = 0;
            mWinErr = 0;
        end else begin
            mWinCnt++;
            mWinErr = total;
        end
        mP = (mP + (slip ? 2 : 1)) % 32;
    endfunction

    function automatic bit nextTx();
        bit b;
        b    = patVec[31 - txPh];
        txPh = (txPh + 1) % 32;
        return b;
    endfunction

    task automatic checkCounters(input string tag);
        check({tag, ".locked"}, {31'd0, locked}, {31'd0, mLocked});
        check({tag, ".bit"},  bit_count,  32'(mBit));
        check({tag, ".err"},  err_count,  32'(mErr));
        check({tag, ".slip"}, {16'd0, slip_count}, 32'(mSlip));
        check({tag, ".loss"}, {16'd0, loss_count}, 32'(mLoss));
    endtask

    // One clock: drive inputs, step model on an accepted beat, compare lock state.
    task automatic cycle(input bit v, input bit d, input bit clr);
        logic [7:0] data;
        data    = 8'($urandom);
        data[0] = d;
        busIf.s_tvalid = v;
        busIf.s_tdata  = data;
        clear          = clr;
        @(posedge clk);
        #1;
        if (v && mReady) begin
            modelBeat(d);
            nBeats++;
        end
        if (clr) begin
            mBit = 0; mErr = 0; mSlip = 0; mLoss = 0;
        end
        mReady = 1;
        check("locked_track", {31'd0, locked}, {31'd0, mLocked});
        busIf.s_tvalid = 1'b0;
        clear          = 1'b0;
    endtask

    task automatic sendPat(input int n, input int flipEvery, input bit inv);
        bit d;
        for (int i = 0; i < n; i++) begin
            d = nextTx() ^ inv;
            if (flipEvery > 0 && (i % flipEvery) == flipEvery - 1) d = ~d;
            cycle(1'b1, d, 1'b0);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        busIf.s_tvalid = 1'b0;
        clear = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        modelReset();
        nBeats = 0;
        check("rst.tready", {31'd0, busIf.s_tready}, 32'd0);
        checkCounters("rst");
        reset = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        check("rst.tready_up", {31'd0, busIf.s_tready}, 32'd1);
    endtask

    initial begin
        int k;
        int ph;
        int cyc;
        reset = 1'b1;
        clear = 1'b0;
        busIf.s_tvalid = 1'b0;
        busIf.s_tdata  = '0;
        modelReset();

        // 1: clean pattern at phase 0
        txPh = 0;
        doReset();
        sendPat(63, 0, 0);
        check("t1.unlocked_b63", {31'd0, locked}, 32'd0);
        sendPat(1, 0, 0);
        check("t1.locked_b64", {31'd0, locked}, 32'd1);
        sendPat(320, 0, 0);
        check("t1.slip", {16'd0, slip_count}, 32'd0);
        check("t1.bit", bit_count, 32'd320);
        check("t1.err", err_count, 32'd0);
        checkCounters("t1");

        // 2: phase offset 5 needs five slips
        txPh = 5;
        doReset();
        sendPat(383, 0, 0);
        check("t2.unlocked_b383", {31'd0, locked}, 32'd0);
        sendPat(1, 0, 0);
        check("t2.locked_b384", {31'd0, locked}, 32'd1);
        check("t2.slip", {16'd0, slip_count}, 32'd5);
        sendPat(128, 0, 0);
        check("t2.slip_hold", {16'd0, slip_count}, 32'd5);
        checkCounters("t2");

        // 3: sparse errors while locked
        txPh = 0;
        doReset();
        sendPat(64, 0, 0);
        sendPat(1000, 100, 0);
        check("t3.err", err_count, 32'd10);
        check("t3.bit", bit_count, 32'd1000);
        check("t3.locked", {31'd0, locked}, 32'd1);
        check("t3.loss", {16'd0, loss_count}, 32'd0);

        // 4: one fully inverted window drops lock, clean data relocks
        sendPat((64 - (nBeats % 64)) % 64, 0, 0);
        sendPat(64, 0, 1);
        check("t4.unlocked", {31'd0, locked}, 32'd0);
        check("t4.loss", {16'd0, loss_count}, 32'd1);
        k = 0;
        while (!locked && k < 32 * 64) begin
            sendPat(1, 0, 0);
            k++;
        end
        check("t4.relocked", {31'd0, locked}, 32'd1);
        check("t4.slip", {16'd0, slip_count}, 32'd0);
        checkCounters("t4");

        // Random starting phase: slips equal the offset, acquisition within PAT_LEN windows
        for (int r = 0; r < 2; r++) begin
            ph   = $urandom_range(1, 31);
            txPh = ph;
            doReset();
            k = 0;
            while (!locked && k < 33 * 64) begin
                sendPat(1, 0, 0);
                k++;
            end
            check("rnd.locked", {31'd0, locked}, 32'd1);
            check("rnd.slip", {16'd0, slip_count}, 32'(ph));
            sendPat(64 + $urandom_range(0, 63), 0, 0);
            checkCounters("rnd");
        end

        // 5: 30% valid duty gives the same totals
        txPh = 0;
        doReset();
        cyc = 0;
        while (nBeats < 384 && cyc < 5000) begin
            if ($urandom_range(0, 99) < 30) cycle(1'b1, nextTx(), 1'b0);
            else                            cycle(1'b0, 1'b0, 1'b0);
            nNotReady(cyc);
            cyc++;
        end
        check("t5.beats", 32'(nBeats), 32'd384);
        check("t5.bit", bit_count, 32'd320);
        check("t5.err", err_count, 32'd0);
        check("t5.slip", {16'd0, slip_count}, 32'd0);
        check("t5.loss", {16'd0, loss_count}, 32'd0);
        check("t5.locked", {31'd0, locked}, 32'd1);

        // 6a: clear on an errored locked beat wins
        cycle(1'b1, ~nextTx(), 1'b1);
        check("t6a.bit", bit_count, 32'd0);
        check("t6a.err", err_count, 32'd0);
        check("t6a.slip", {16'd0, slip_count}, 32'd0);
        check("t6a.loss", {16'd0, loss_count}, 32'd0);
        check("t6a.locked", {31'd0, locked}, 32'd1);
        sendPat(10, 0, 0);
        checkCounters("t6a_after");

        // 6b: reset mid-LOCKED
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t6b.locked", {31'd0, locked}, 32'd0);
        check("t6b.bit", bit_count, 32'd0);
        check("t6b.err", err_count, 32'd0);
        check("t6b.tready", {31'd0, busIf.s_tready}, 32'd0);

        // 6c: err_count saturates at all-ones
        txPh = 0;
        doReset();
        sendPat(64, 0, 0);
        force dut.uErrCnt.cnt = 32'hFFFF_FFFF;
        #1;
        release dut.uErrCnt.cnt;
        mErr = 64'hFFFF_FFFF;
        sendPat(30, 10, 0);
        check("t6c.err_sat", err_count, 32'hFFFF_FFFF);
        checkCounters("t6c");

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

    task automatic nNotReady(input int c);
        check($sformatf("t5.tready_%0d", c), {31'd0, busIf.s_tready}, 32'd1);
    endtask

endmodule

// File: doc/viterbi_ber_checker.md
Name: viterbi_ber_checker

Overview:
- Receive end of the encoder/decoder loopback test. Consumes the decoded bit stream from viterbi_dec and aligns it to the known cyclic test pattern that drives conv_encoder.
- Finds pattern phase by slipping and declares lock. Counts bits and bit errors while locked.
- Detects loss of sync.
- Counters feed the ILA/debug registers.

Parameters:
- PAT_LEN, 32, period of the reference pattern in bits.
- PATTERN, 32'h0200af31, reference pattern; transmitted MSB first.
- WIN_LEN, 64, bits per sync-evaluation window.
- LOCK_THRESH, 2, max mismatches in a HUNT window that still declares lock.
- UNLOCK_THRESH, 8, mismatches in a LOCKED window above which sync is lost.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous clear of statistics counters only.
- s_tvalid  in  1  decoded bit valid.
- s_tready  out  1  checker ready.
- s_tdata  in  8  decoded data; only bit 0 is used.
- locked  out  1  pattern lock indicator.
- bit_count  out  32  bits checked while locked; saturating.
- err_count  out  32  mismatches while locked; saturating.
- slip_count  out  16  phase slips performed; saturating.
- loss_count  out  16  LOCKED->HUNT transitions; saturating.

Behaviour:
- Reset is on clk. While reset=1:
  - s_tready=0, state=HUNT, phase p=0, window counters 0.
  - locked=0 and all counters 0.
- s_tready is registered: it is 1 from the first cycle after reset deasserts. Never deasserts otherwise; the block never back-pressures.
- Beat = cycle with s_tvalid&s_tready. Only beats advance any state; idle cycles change nothing.
- Per beat:
  - exp = PATTERN[PAT_LEN-1-p]; mis = s_tdata[0]^exp.
  - p <= (p+1) mod PAT_LEN, or (p+2) mod PAT_LEN on a slip beat.
  - win_cnt increments from 0 to WIN_LEN-1. win_err accumulates mis. The total includes the current beat.
- Window close = beat with win_cnt==WIN_LEN-1. On close, win_cnt and win_err restart at 0.
- State HUNT:
  - At close, if total <= LOCK_THRESH: go to LOCKED, locked=1 the next cycle.
  - Otherwise slip on this beat and increment slip_count.
- State LOCKED:
  - Each beat increments bit_count and adds mis to err_count.
  - At close, if total > UNLOCK_THRESH: go to HUNT, locked=0 the next cycle, increment loss_count. The closing beat is still counted.
- Beats in HUNT, including the beat that closes a successful HUNT window, are not added to bit_count or err_count.
- Output latency: all outputs are registered and reflect a beat on the cycle after it is accepted.
- Counter saturation: every counter holds at its all-ones value and does not wrap.
- clear:
  - Zeroes bit_count, err_count, slip_count, loss_count.
  - If clear coincides with a beat, clear wins: that beat's increments are dropped. State, p and window counters are unaffected.
- reset mid-operation: immediate return to the reset values above, regardless of state.
- PATTERN requirement: every nonzero rotation must differ from PATTERN in more than LOCK_THRESH bits over WIN_LEN bits. The default has at least 20 differences per 64-bit window.
- Worst-case acquisition: PAT_LEN windows.

Decomposition:
- Package viterbi_test_pkg holds:
  - enum typedef sync_state_t {HUNT, LOCKED};
  - constant DEFAULT_TEST_PATTERN = 32'h0200af31;
  - localparam widths for the counter outputs.
- One sub-module: sat_counter, parameterised width, with inputs inc/amount/clr and a saturating output. It is instantiated for all four statistics counters.

Test Plan:
1. Error-free pattern, phase 0, continuous valid, 384 beats -> locked=1 the cycle after beat 64, slip_count=0, bit_count=320, err_count=0.
2. Error-free pattern starting at phase 5 -> slip_count=5; locked=1 the cycle after beat 384; slip_count unchanged afterwards.
3. Lock as in case 1, then 1000 beats with one flipped bit every 100 -> err_count=10, bit_count=1000, locked stays 1, loss_count=0.
4. Locked, then 64 beats of inverted pattern aligned to one window:
   - locked=0 after that window closes and loss_count=1;
   - clean pattern afterwards gives relock within 32 windows, with slip_count matching the residual phase.
5. Case 1 repeated with s_tvalid at a pseudo-random 30% duty -> identical final counter values; s_tready stays 1 throughout.
6. Boundary cases:
   - clear asserted on an errored beat while locked -> all counters 0 next cycle, locked unchanged.
   - reset asserted mid-LOCKED -> locked=0, counters 0, s_tready=0 next cycle.
   - err_count preloaded via force to 32'hFFFFFFFF -> stays 32'hFFFFFFFF after further errors.
